alu: RTL and testbench

32-bit integer arithmetic/logic unit for the single-cycle/pipelined MIPS-style datapath. Combines operands SrcA and SrcB under a 3-bit ALUControl code (add, sub, and, or, xor, nor, slt, sltu) and produces a 32-bit result, a Zero flag, and signed-overflow/carry flags. Sits in the execute stage, fed by the register file/immediate mux and the ALU decoder. The result drives memory address, write-back and branch-compare logic.

---
 rtl/alu.sv | 105 ++++++++++
 tb/tb_alu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 32-bit MIPS-style ALU: add/sub/and/or/xor/nor/slt/sltu with Zero, Overflow and CarryOut.
// Define ALU_OUTPUT_REG_EN to register all outputs (1-cycle latency); otherwise purely combinational.
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic [2:0]  ALUControl,
   output logic [31:0] ALUResult,
   output logic        Zero,
   output logic        Overflow,
   output logic        CarryOut
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_NOR  = 3'b101,
      OP_SLT  = 3'b110,
      OP_SLTU = 3'b111
   } alu_op_e;

   alu_op_e     op;
   logic        is_sub;
   logic [31:0] b_op;
   logic [32:0] sum;
   logic        ov_raw;
   logic        lt_s;
   logic        lt_u;
   logic [31:0] res_d;
   logic        zero_d;
   logic        ov_d;
   logic        co_d;

   assign op = alu_op_e'(ALUControl);

   // One shared 33-bit adder serves add, sub and both compares.
   assign is_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   assign b_op   = is_sub ? ~SrcB : SrcB;
   assign sum    = {1'b0, SrcA} + {1'b0, b_op} + {32'd0, is_sub};
   assign ov_raw = (SrcA[31] == b_op[31]) && (sum[31] != SrcA[31]);
   assign lt_s   = sum[31] ^ ov_raw;
   assign lt_u   = ~sum[32];

   always_comb begin
      res_d = 32'd0;
      ov_d  = 1'b0;
      co_d  = 1'b0;
      unique case (op)
         OP_ADD, OP_SUB: begin
            res_d = sum[31:0];
            ov_d  = ov_raw;
            co_d  = sum[32];
         end
         OP_AND:  res_d = SrcA & SrcB;
         OP_OR:   res_d = SrcA | SrcB;
         OP_XOR:  res_d = SrcA ^ SrcB;
         OP_NOR:  res_d = ~(SrcA | SrcB);
         OP_SLT:  res_d = {31'd0, lt_s};
         OP_SLTU: res_d = {31'd0, lt_u};
         default: res_d = 32'd0;
      endcase
   end

   assign zero_d = (res_d == 32'd0);

`ifdef ALU_OUTPUT_REG_EN
   logic [31:0] res_q;
   logic        zero_q;
   logic        ov_q;
   logic        co_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q  <= 32'd0;
         zero_q <= 1'b1;
         ov_q   <= 1'b0;
         co_q   <= 1'b0;
      end else begin
         res_q  <= res_d;
         zero_q <= zero_d;
         ov_q   <= ov_d;
         co_q   <= co_d;
      end
   end

   assign ALUResult = res_q;
   assign Zero      = zero_q;
   assign Overflow  = ov_q;
   assign CarryOut  = co_q;
`else
   // Clock and reset are kept on the port list so both builds share one footprint.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   assign ALUResult = res_d;
   assign Zero      = zero_d;
   assign Overflow  = ov_d;
   assign CarryOut  = co_d;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes reference-model results, negedge monitor pops and compares.
// Works for both the combinational build and the ALU_OUTPUT_REG_EN build.
module tb_alu;

   typedef struct packed {
      logic [31:0] r;
      logic        z;
      logic        o;
      logic        c;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } item_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [2:0]  ALUControl;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        Overflow;
   logic        CarryOut;

   int   n_checks = 0;
   int   n_pass   = 0;
   item_t sb_q[$];
   logic issued   = 1'b0;
   logic issued_q;

   alu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .Overflow   (Overflow),
      .CarryOut   (CarryOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string op_name(logic [2:0] op);
      case (op)
         3'd0: return "add";
         3'd1: return "sub";
         3'd2: return "and";
         3'd3: return "or";
         3'd4: return "xor";
         3'd5: return "nor";
         3'd6: return "slt";
         default: return "sltu";
      endcase
   endfunction

   // Reference model: wide integer arithmetic, signed range test for overflow.
   function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      exp_t        e;
      logic [63:0] u;
      longint      sa, sb, s;
      longint      maxs, mins;
      maxs = 64'sh7FFF_FFFF;
      mins = -64'sh8000_0000;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e  = '0;
      case (op)
         3'd0: begin
            u   = {32'd0, a} + {32'd0, b};
            s   = sa + sb;
            e.r = u[31:0];
            e.c = u[32];
            e.o = (s > maxs) || (s < mins);
         end
         3'd1: begin
            u   = {32'd0, a} + {32'd0, ~b} + 64'd1;
            s   = sa - sb;
            e.r = u[31:0];
            e.c = u[32];
            e.o = (s > maxs) || (s < mins);
         end
         3'd2: e.r = a & b;
         3'd3: e.r = a | b;
         3'd4: e.r = a ^ b;
         3'd5: e.r = ~(a | b);
         3'd6: e.r = (sa < sb) ? 32'd1 : 32'd0;
         default: e.r = (a < b) ? 32'd1 : 32'd0;
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   task automatic check(string name, exp_t got, exp_t exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got r=%h z=%b o=%b c=%b, expected r=%h z=%b o=%b c=%b",
                    name, got.r, got.z, got.o, got.c, exp.r, exp.z, exp.o, exp.c);
   endtask

   function automatic exp_t dut_out();
      exp_t g;
      g.r = ALUResult;
      g.z = Zero;
      g.o = Overflow;
      g.c = CarryOut;
      return g;
   endfunction

   localparam exp_t RST_VAL = '{r: 32'd0, z: 1'b1, o: 1'b0, c: 1'b0};

   always @(posedge clk or negedge rst_n)
      if (!rst_n) issued_q <= 1'b0;
      else        issued_q <= issued;

   logic mon_vld;
`ifdef ALU_OUTPUT_REG_EN
   assign mon_vld = issued_q;
`else
   assign mon_vld = issued;
`endif

   // Monitor: one result per cycle whenever an operation is due at the output.
   always @(negedge clk) begin
      if (mon_vld) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: output valid but no expected entry");
         end else begin
            item_t it;
            it = sb_q.pop_front();
            check($sformatf("%s a=%h b=%h", op_name(it.op), it.a, it.b), dut_out(), it.e);
         end
      end
   end

   task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      item_t it;
      @(posedge clk);
      #1;
      SrcA       = a;
      SrcB       = b;
      ALUControl = op;
      it.op = op;
      it.a  = a;
      it.b  = b;
      it.e  = model(op, a, b);
      sb_q.push_back(it);
      issued = 1'b1;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      issued = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] sp [5];
      sp[0] = 32'h0;
      sp[1] = 32'h1;
      sp[2] = 32'hFFFF_FFFF;
      sp[3] = 32'h8000_0000;
      sp[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      rst_n      = 1'b0;
      SrcA       = 32'd5;
      SrcB       = 32'd6;
      ALUControl = 3'd0;
      #3;
`ifdef ALU_OUTPUT_REG_EN
      check("reset_state", dut_out(), RST_VAL);
`else
      check("reset_state_comb", dut_out(), model(3'd0, 32'd5, 32'd6));
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      issue(3'd0, 32'd25, 32'd100);
      issue(3'd1, 32'd333, 32'd1024);
      issue(3'd2, 32'hF0F0, 32'h0F0F);
      issue(3'd3, 32'hA0A0, 32'h5F5F);
      issue(3'd4, 32'h1212, 32'h3232);
      issue(3'd5, 32'h2222, 32'h2222);
      issue(3'd6, 32'hF345, 32'h7354);
      issue(3'd7, 32'hF123, 32'h7811);
      issue(3'd6, 32'h8000_0000, 32'd1);
      issue(3'd7, 32'h8000_0000, 32'd1);
      issue(3'd0, 32'h7FFF_FFFF, 32'd1);
      issue(3'd1, 32'h8000_0000, 32'd1);
      issue(3'd6, 32'h8000_0000, 32'h7FFF_FFFF);
      issue(3'd0, 32'hFFFF_FFFF, 32'd1);
      issue(3'd1, 32'd7, 32'd7);

      // Random stimulus
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, b;
         a = pick();
         b = ($urandom_range(0, 7) == 0) ? a : pick();
         issue(3'($urandom_range(0, 7)), a, b);
      end
      idle();
      idle();

      // Bounded drain of the scoreboard
      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", sb_q.size());

`ifdef ALU_OUTPUT_REG_EN
      begin
         exp_t held;
         // Registered outputs ignore input changes between edges
         SrcA = 32'h1234_5678; SrcB = 32'h0F0F_0F0F; ALUControl = 3'd4;
         @(posedge clk); #1;
         held = model(3'd4, 32'h1234_5678, 32'h0F0F_0F0F);
         SrcA = 32'hDEAD_BEEF; ALUControl = 3'd0;
         #2;
         check("hold_between_edges", dut_out(), held);

         // Mid-stream reset discards the pending result at once
         SrcA = 32'h7FFF_FFFF; SrcB = 32'd1; ALUControl = 3'd0;
         @(posedge clk); #1;
         check("pre_reset_value", dut_out(), model(3'd0, 32'h7FFF_FFFF, 32'd1));
         SrcA = 32'd9; SrcB = 32'd4; ALUControl = 3'd1;
         #1;
         rst_n = 1'b0;
         #1;
         check("async_reset", dut_out(), RST_VAL);
         @(posedge clk); #1;
         check("reset_held", dut_out(), RST_VAL);
         rst_n = 1'b1;
         SrcA = 32'd25; SrcB = 32'd100; ALUControl = 3'd0;
         #1;
         check("post_release_before_edge", dut_out(), RST_VAL);
         @(posedge clk); #1;
         check("post_release_latency", dut_out(), model(3'd0, 32'd25, 32'd100));
      end
`else
      // Combinational build: reset has no effect on outputs
      rst_n = 1'b0;
      SrcA = 32'd25; SrcB = 32'd100; ALUControl = 3'd0;
      #1;
      check("comb_ignores_reset", dut_out(), model(3'd0, 32'd25, 32'd100));
      rst_n = 1'b1;
      #1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
